// File: rtl/alu_acc_seq_if.sv
// Command/response handshake bundle between a host and the accumulator sequencer.
// The accumulator and flags travel with the response side.
interface alu_acc_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] acc;
  logic       flag_z;
  logic       flag_c;
  logic       flag_v;
  logic       flag_n;

  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, acc,
    input  flag_z, flag_c, flag_v, flag_n
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, acc,
    output flag_z, flag_c, flag_v, flag_n
  );
endinterface

// File: rtl/alu_acc_seq.sv
// Accumulator sequencer: feeds an external 8-bit ALU, waits a settle time,
// writes the result back and returns flags over a valid/ready response.
module alu_acc_seq #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_acc_seq_if.slave     io,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_op,
  input  logic [7:0]       alu_z,
  input  logic             alu_ov,
  input  logic             alu_cout,
  input  logic             alu_sign,
  output logic             sticky_v,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic [3:0] LAST = 4'(EXEC_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             fz_q, fz_d;
  logic             fc_q, fc_d;
  logic             fv_q, fv_d;
  logic             fn_q, fn_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] opcnt_q, opcnt_d;
  logic             rdy_q, rdy_d;
  logic             rsp_q, rsp_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    op_d     = op_q;
    fz_d     = fz_q;
    fc_d     = fc_q;
    fv_d     = fv_q;
    fn_d     = fn_q;
    opcnt_d  = opcnt_q;
    rdy_d    = rdy_q;
    rsp_d    = rsp_q;
    sticky_d = clr_sticky ? 1'b0 : sticky_q;
    unique case (state_q)
      IDLE: begin
        if (io.cmd_valid) begin
          rdy_d = 1'b0;
          unique case (1'b1)
            io.cmd_load: begin
              acc_d   = io.cmd_data;
              fz_d    = (io.cmd_data == 8'h00);
              fn_d    = io.cmd_data[7];
              fc_d    = 1'b0;
              fv_d    = 1'b0;
              rsp_d   = 1'b1;
              state_d = RESP;
            end
            default: begin
              b_d     = io.cmd_data;
              op_d    = io.cmd_op;
              cnt_d   = 4'd0;
              state_d = EXEC;
            end
          endcase
        end
      end
      EXEC: begin
        if (cnt_q == LAST) begin
          acc_d   = alu_z;
          fz_d    = (alu_z == 8'h00);
          fc_d    = alu_cout;
          fv_d    = alu_ov;
          fn_d    = alu_sign;
          opcnt_d = opcnt_q + 1'b1;
          rsp_d   = 1'b1;
          state_d = RESP;
          // a new overflow beats a simultaneous clear
          if (alu_ov) sticky_d = 1'b1;
        end
        cnt_d = cnt_q + 4'd1;
      end
      RESP: begin
        if (io.rsp_ready) begin
          rsp_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        rsp_d   = 1'b0;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      op_q     <= '0;
      fz_q     <= 1'b0;
      fc_q     <= 1'b0;
      fv_q     <= 1'b0;
      fn_q     <= 1'b0;
      sticky_q <= 1'b0;
      opcnt_q  <= '0;
      rdy_q    <= 1'b1;
      rsp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      op_q     <= op_d;
      fz_q     <= fz_d;
      fc_q     <= fc_d;
      fv_q     <= fv_d;
      fn_q     <= fn_d;
      sticky_q <= sticky_d;
      opcnt_q  <= opcnt_d;
      rdy_q    <= rdy_d;
      rsp_q    <= rsp_d;
    end
  end

  assign io.cmd_ready = rdy_q;
  assign io.rsp_valid = rsp_q;
  assign io.acc       = acc_q;
  assign io.flag_z    = fz_q;
  assign io.flag_c    = fc_q;
  assign io.flag_v    = fv_q;
  assign io.flag_n    = fn_q;
  assign alu_a        = acc_q;
  assign alu_b        = b_q;
  assign alu_op       = op_q;
  assign sticky_v     = sticky_q;
  assign op_count     = opcnt_q;

endmodule

// File: tb/tb_alu_acc_seq.sv
// Directed bench for alu_acc_seq: two instances (settle 1 and 4 cycles)
// driven from one sequence, each closed around a behavioural ALU.
module tb_alu_acc_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       cmd_valid = 1'b0;
  logic       cmd_load  = 1'b0;
  logic [2:0] cmd_op    = 3'd0;
  logic [7:0] cmd_data  = 8'h00;
  logic       rsp_ready = 1'b0;
  logic       clr       = 1'b0;
  bit         s         = 1'b0;

  int ec [2] = '{1, 4};

  alu_acc_seq_if if1 ();
  alu_acc_seq_if if4 ();

  assign if1.cmd_valid = cmd_valid & ~s;
  assign if4.cmd_valid = cmd_valid & s;
  assign if1.rsp_ready = rsp_ready & ~s;
  assign if4.rsp_ready = rsp_ready & s;
  assign if1.cmd_load  = cmd_load;
  assign if4.cmd_load  = cmd_load;
  assign if1.cmd_op    = cmd_op;
  assign if4.cmd_op    = cmd_op;
  assign if1.cmd_data  = cmd_data;
  assign if4.cmd_data  = cmd_data;

  function automatic logic [10:0] alu_f(
    input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [8:0] r;
    logic [7:0] z;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        r = {1'b0, a} + {1'b0, b};
        z = r[7:0];
        c = r[8];
        v = (a[7] == b[7]) && (z[7] != a[7]);
      end
      3'd1: begin
        r = {1'b0, a} - {1'b0, b};
        z = r[7:0];
        c = r[8];
        v = (a[7] != b[7]) && (z[7] != a[7]);
      end
      3'd2: z = a & b;
      3'd3: z = a | b;
      3'd4: z = a ^ b;
      3'd5: z = ~a;
      3'd6: begin
        z = a >> 1;
        c = a[0];
        v = a[7] ^ z[7];
      end
      default: begin
        z = a << 1;
        c = a[7];
        v = a[7] ^ z[7];
      end
    endcase
    return {z[7], c, v, z};
  endfunction

  logic [7:0] a1, b1, z1, a4, b4, z4;
  logic [2:0] op1, op4;
  logic ov1, co1, sg1, ov4, co4, sg4, sv1, sv4;
  logic [7:0] cnt1, cnt4;

  assign {sg1, co1, ov1, z1} = alu_f(a1, b1, op1);
  assign {sg4, co4, ov4, z4} = alu_f(a4, b4, op4);

  alu_acc_seq #(.EXEC_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .io(if1),
    .alu_a(a1), .alu_b(b1), .alu_op(op1),
    .alu_z(z1), .alu_ov(ov1), .alu_cout(co1), .alu_sign(sg1),
    .sticky_v(sv1), .clr_sticky(clr), .op_count(cnt1)
  );

  alu_acc_seq #(.EXEC_CYCLES(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .io(if4),
    .alu_a(a4), .alu_b(b4), .alu_op(op4),
    .alu_z(z4), .alu_ov(ov4), .alu_cout(co4), .alu_sign(sg4),
    .sticky_v(sv4), .clr_sticky(clr), .op_count(cnt4)
  );

  logic       o_rdy, o_rsp, o_fz, o_fc, o_fv, o_fn, o_sv;
  logic [7:0] o_acc, o_cnt, o_a, o_b;
  logic [2:0] o_op;

  assign o_rdy = s ? if4.cmd_ready : if1.cmd_ready;
  assign o_rsp = s ? if4.rsp_valid : if1.rsp_valid;
  assign o_acc = s ? if4.acc : if1.acc;
  assign o_fz  = s ? if4.flag_z : if1.flag_z;
  assign o_fc  = s ? if4.flag_c : if1.flag_c;
  assign o_fv  = s ? if4.flag_v : if1.flag_v;
  assign o_fn  = s ? if4.flag_n : if1.flag_n;
  assign o_sv  = s ? sv4 : sv1;
  assign o_cnt = s ? cnt4 : cnt1;
  assign o_a   = s ? a4 : a1;
  assign o_b   = s ? b4 : b1;
  assign o_op  = s ? op4 : op1;

  typedef struct {
    logic [7:0] acc;
    logic z, c, v, n, sv;
    logic [7:0] cnt;
    int lat;
  } exp_t;

  exp_t sb[$];
  logic [7:0] acc_m [2];
  logic       sv_m  [2];
  logic [7:0] cnt_m [2];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      acc_m[i] = 8'h00;
      sv_m[i]  = 1'b0;
      cnt_m[i] = 8'h00;
    end
  endtask

  task automatic do_cmd(input logic ld, input logic [2:0] op,
                        input logic [7:0] d, input bit clr_cap,
                        input int hold);
    exp_t e;
    logic [10:0] r;
    logic [7:0] a_prev;
    int lat;
    @(negedge clk);
    chk("cmd_ready_idle", o_rdy, 1);
    cmd_valid = 1'b1;
    cmd_load  = ld;
    cmd_op    = op;
    cmd_data  = d;
    a_prev = acc_m[s];
    e.cnt = cnt_m[s];
    e.sv  = sv_m[s];
    if (ld) begin
      e.acc = d;
      e.c = 1'b0;
      e.v = 1'b0;
      e.n = d[7];
      e.lat = 1;
    end else begin
      r = alu_f(a_prev, d, op);
      e.acc = r[7:0];
      e.v = r[8];
      e.c = r[9];
      e.n = r[10];
      e.sv = r[8] | (sv_m[s] & ~clr_cap);
      e.cnt = cnt_m[s] + 8'd1;
      e.lat = ec[s] + 1;
    end
    e.z = (e.acc == 8'h00);
    acc_m[s] = e.acc;
    sv_m[s]  = e.sv;
    cnt_m[s] = e.cnt;
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!o_rsp && lat < 64) begin
      chk("alu_a_hold", o_a, a_prev);
      chk("alu_b_hold", o_b, d);
      chk("alu_op_hold", o_op, op);
      chk("cmd_ready_exec", o_rdy, 0);
      if (clr_cap && lat == ec[s]) clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      lat++;
    end
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("acc", o_acc, e.acc);
    chk("flag_z", o_fz, e.z);
    chk("flag_c", o_fc, e.c);
    chk("flag_v", o_fv, e.v);
    chk("flag_n", o_fn, e.n);
    chk("sticky_v", o_sv, e.sv);
    chk("op_count", o_cnt, e.cnt);
    if (hold > 0) begin
      cmd_valid = 1'b1;
      cmd_load  = 1'b1;
      cmd_data  = ~d;
      repeat (hold) begin
        @(negedge clk);
        chk("hold_rsp_valid", o_rsp, 1);
        chk("hold_cmd_ready", o_rdy, 0);
        chk("hold_acc", o_acc, e.acc);
        chk("hold_flags", {o_fz, o_fc, o_fv, o_fn},
            {e.z, e.c, e.v, e.n});
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", o_rsp, 0);
    chk("cmd_ready_back", o_rdy, 1);
    chk("acc_after_hs", o_acc, e.acc);
    cmd_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s = i[0];
      #1;
      chk("rst_acc", o_acc, 0);
      chk("rst_rsp", o_rsp, 0);
      chk("rst_cnt", o_cnt, 0);
      chk("rst_rdy", o_rdy, 1);
      chk("rst_sticky", o_sv, 0);
      chk("rst_b_op", {o_b, o_op}, 0);
      chk("rst_flags", {o_fz, o_fc, o_fv, o_fn}, 0);
    end
    s = 1'b0;

    do_cmd(1'b1, 3'd0, 8'hF0, 1'b0, 0);
    do_cmd(1'b0, 3'd0, 8'h20, 1'b0, 0);
    do_cmd(1'b1, 3'd0, 8'h10, 1'b0, 0);
    do_cmd(1'b0, 3'd1, 8'h10, 1'b0, 0);
    do_cmd(1'b1, 3'd0, 8'h80, 1'b0, 0);
    do_cmd(1'b0, 3'd6, 8'h00, 1'b0, 0);
    do_cmd(1'b1, 3'd0, 8'h7F, 1'b0, 0);
    do_cmd(1'b0, 3'd0, 8'h01, 1'b1, 0);
    do_cmd(1'b0, 3'd4, 8'hFF, 1'b1, 0);
    do_cmd(1'b0, 3'd0, 8'h01, 1'b0, 0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    sv_m[0] = 1'b0;
    chk("clr_idle", o_sv, 0);
    do_cmd(1'b1, 3'd0, 8'h80, 1'b0, 0);
    do_cmd(1'b0, 3'd3, 8'h0F, 1'b0, 5);
    do_cmd(1'b0, 3'd7, 8'h00, 1'b0, 3);
    for (int i = 0; i < 256; i++)
      do_cmd(1'b0, 3'($urandom_range(0, 7)), 8'($urandom), 1'b0, 0);
    chk("wrap_count", o_cnt, cnt_m[0]);

    s = 1'b1;
    do_cmd(1'b1, 3'd0, 8'h55, 1'b0, 0);
    do_cmd(1'b0, 3'd4, 8'h3C, 1'b0, 0);
    do_cmd(1'b1, 3'd0, 8'h55, 1'b0, 0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_load  = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 8'h01;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_acc", o_acc, 8'h55);
    #2 rst_n = 1'b0;
    #1;
    chk("async_acc", o_acc, 0);
    chk("async_rsp", o_rsp, 0);
    chk("async_cnt", o_cnt, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", o_rdy, 1);
    chk("no_rsp_after_rst", o_rsp, 0);
    do_cmd(1'b0, 3'd0, 8'h05, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
